dig_clock_period_meter: RTL and testbench
=========================================

# dig_clock_period_meter

Measures the high and low phase lengths of a slow, divided clock signal in cycles of the fast system clock, and recovers the divider's terminal count. It is the receiving end of the simple clock divider: fed a divider output, it reports the `maxCounter` value that produced it. It sits in Digital's Verilog export library for test fixtures and clock-health monitoring. It is not a clock source.

## Interface
- `WIDTH`, default 32: width of the phase counters; the saturation value is 2^WIDTH-1.
- `cin`  in  1: system clock; all logic runs on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `sig_in`  in  1: divided or slow clock to measure; asynchronous to `cin`.
- `high_len`  out  WIDTH: length in cycles of the last completed high phase.
- `low_len`  out  WIDTH: length in cycles of the last completed low phase.
- `period`  out  WIDTH+1: `high_len + low_len`, zero-extended, never truncated.
- `max_count`  out  WIDTH: length of the most recently completed phase minus 1.
- `meas_valid`  out  1: one-cycle pulse when a phase length is captured.
- `locked`  out  1: the last two captured phases are equal.
- `stalled`  out  1: no edge was seen before the counter saturated.

## Operation
- Synchronizer:
  - `sig_in` passes through two flops, `s1` and `s2`.
  - A third flop, `s3`, holds the previous `s2`.
  - An edge occurs when `s2 != s3`. It is rising when `s2` is 1 and falling when `s2` is 0.
- Phase counter `cnt`:
  - On an edge: `cnt <= 1`.
  - Otherwise, if `cnt != MAX`: `cnt <= cnt + 1`.
- State machine:
  - **IDLE:** no phase start is known. On an edge, go to FIRST and capture nothing.
  - **FIRST:** one edge has been seen. On an edge, capture `cnt` into the phase just ended and go to RUN.
  - **RUN:** on each edge, capture `cnt`.
- Capture rules:
  - A rising edge ends a low phase: `low_len <= cnt`.
  - A falling edge ends a high phase: `high_len <= cnt`.
  - On every capture: `max_count <= cnt - 1`, `meas_valid` = 1 for one cycle, and `period` is recomputed from the updated lengths.
- Lock:
  - A capture made in FIRST leaves `locked` at 0.
  - A capture made in RUN sets `locked <= (cnt == the other phase length register)`.
- Stall:
  - Applies in FIRST or RUN, with no edge, when `cnt == MAX`.
  - Effect: `stalled <= 1`, `locked <= 0`, state goes to IDLE.
  - The length registers keep their values.
- Leaving stall: the next edge clears `stalled` and enters FIRST.
- Simultaneous edge and `cnt == MAX`: the edge wins.
  - MAX is captured as a valid length.
  - No stall is raised.
- In IDLE, `cnt` saturates silently and `stalled` does not re-assert.

## Timing
- Reset values:
  - `s1`, `s2`, `s3`, `cnt` = 0; state = IDLE.
  - `high_len`, `low_len`, `period`, `max_count` = 0.
  - `meas_valid`, `locked`, `stalled` = 0.
- Reset asserted mid-measurement discards everything. After release, the first edge only arms the block (enters FIRST).
- Latency:
  - A `sig_in` transition sampled at `cin` edge k is seen as an edge at edge k+2.
  - The captured outputs and `meas_valid` are visible after edge k+2, i.e. three rising edges from the first sampling edge.
  - `period` and `locked` update in the same cycle as the capture.
- Length definition: a phase of `sig_in` stable across N consecutive sampling edges yields a length of N. The minimum is 1.
- `max_count` wraps: a captured length of 1 gives 0. A length of 0 is impossible.
- `meas_valid` is never high on two consecutive cycles unless `sig_in` toggles every cycle.

## Test plan
- Divider with `maxCounter`=3 driving `sig_in` (4 cycles high, 4 low):
  - First edge: no `meas_valid`.
  - Then `high_len`=4, `low_len`=4, `period`=8, `max_count`=3.
  - `locked` rises on the second capture.
- Asymmetric 3 high / 5 low:
  - `high_len`=3, `low_len`=5, `period`=8.
  - `max_count` alternates 2 and 4; `locked` stays 0.
- `WIDTH`=4, `sig_in` held constant after lock:
  - `stalled`=1 and `locked`=0 when `cnt` reaches 15.
  - The next edge clears `stalled` without a `meas_valid`.
  - The following edge produces a capture.
- `WIDTH`=4, phase of exactly 15 cycles:
  - Edge coincides with `cnt`=15.
  - Capture of 15 with `meas_valid`=1 and `stalled`=0.
- `rst_n` pulsed low mid-phase while locked:
  - All outputs are 0 immediately (asynchronous).
  - After release, the first edge gives no capture and the second gives correct lengths.
- `sig_in` toggling every cycle:
  - Lengths of 1, `max_count`=0, `period`=2.
  - `meas_valid` high every cycle and `locked`=1.

Source files
------------

// File: rtl/dig_clock_period_meter.sv
// rtl/dig_clock_period_meter.sv - high/low phase length meter and divider terminal-count recovery
module dig_clock_period_meter #(
    parameter int WIDTH = 32
) (
    input  logic             cin,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [WIDTH-1:0] high_len,
    output logic [WIDTH-1:0] low_len,
    output logic [WIDTH:0]   period,
    output logic [WIDTH-1:0] max_count,
    output logic             meas_valid,
    output logic             locked,
    output logic             stalled
);

    localparam logic [WIDTH-1:0] MAX   = '1;
    localparam logic [1:0]       IDLE  = 2'd0;
    localparam logic [1:0]       FIRST = 2'd1;
    localparam logic [1:0]       RUN   = 2'd2;

    logic             s1, s2, s3;
    logic [WIDTH-1:0] cnt;
    logic [1:0]       state;
    logic             sig_edge;
    logic             capture;
    logic [WIDTH-1:0] next_high;
    logic [WIDTH-1:0] next_low;

    // Edge detection on the synchronized signal; a capture needs a known phase start
    always_comb begin
        sig_edge  = s2 ^ s3;
        capture   = sig_edge && (state != IDLE);
        next_high = high_len;
        next_low  = low_len;
        if (capture) begin
            if (s2) begin
                next_low = cnt;
            end else begin
                next_high = cnt;
            end
        end
    end

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Phase counter: restarts at 1 on every edge, saturates at MAX otherwise
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sig_edge) begin
            cnt <= {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (cnt != MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Arming FSM with capture, lock and stall handling; an edge always beats saturation
    always_ff @(posedge cin or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            high_len   <= '0;
            low_len    <= '0;
            period     <= '0;
            max_count  <= '0;
            meas_valid <= 1'b0;
            locked     <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            meas_valid <= capture;
            case (state)
                IDLE: begin
                    if (sig_edge) begin
                        state   <= FIRST;
                        stalled <= 1'b0;
                    end
                end
                FIRST, RUN: begin
                    if (sig_edge) begin
                        high_len  <= next_high;
                        low_len   <= next_low;
                        period    <= {1'b0, next_high} + {1'b0, next_low};
                        max_count <= cnt - 1'b1;
                        // Compare against the opposite phase register as it stood before this capture
                        locked    <= (state == RUN) && (cnt == (s2 ? high_len : low_len));
                        state     <= RUN;
                    end else if (cnt == MAX) begin
                        stalled <= 1'b1;
                        locked  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dig_clock_period_meter.sv
// tb/tb_dig_clock_period_meter.sv - randomized and directed bench against a run-length reference model
module tb_dig_clock_period_meter;

    typedef struct {
        longint hl;
        longint ll;
        longint per;
        longint mc;
        bit     mv;
        bit     lk;
        bit     st;
    } exp_t;

    logic        cin;
    logic        rst_n;
    logic        sig_in;

    logic [31:0] a_hl, a_ll, a_mc;
    logic [32:0] a_per;
    logic        a_mv, a_lk, a_st;
    logic [3:0]  b_hl, b_ll, b_mc;
    logic [4:0]  b_per;
    logic        b_mv, b_lk, b_st;

    int n_assert = 0;
    int n_fail   = 0;

    exp_t   cur  [2];
    bit     prev [2];
    longint run  [2];
    int     nedge[2];
    longint maxv [2];
    exp_t   qa[$];
    exp_t   qb[$];

    dig_clock_period_meter #(.WIDTH(32)) dut_a (
        .cin(cin), .rst_n(rst_n), .sig_in(sig_in),
        .high_len(a_hl), .low_len(a_ll), .period(a_per), .max_count(a_mc),
        .meas_valid(a_mv), .locked(a_lk), .stalled(a_st)
    );

    dig_clock_period_meter #(.WIDTH(4)) dut_b (
        .cin(cin), .rst_n(rst_n), .sig_in(sig_in),
        .high_len(b_hl), .low_len(b_ll), .period(b_per), .max_count(b_mc),
        .meas_valid(b_mv), .locked(b_lk), .stalled(b_st)
    );

    initial cin = 1'b0;
    always #5 cin = ~cin;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: run lengths of the raw sample stream; consequences appear two samples later
    task automatic model_reset();
        exp_t z;
        z = '{hl: 0, ll: 0, per: 0, mc: 0, mv: 0, lk: 0, st: 0};
        for (int i = 0; i < 2; i++) begin
            cur[i]   = z;
            prev[i]  = 1'b0;
            run[i]   = 0;
            nedge[i] = 0;
        end
        qa.delete();
        qb.delete();
        repeat (2) begin
            qa.push_back(z);
            qb.push_back(z);
        end
    endtask

    task automatic model_step(input int i, input bit v);
        longint len;
        cur[i].mv = 1'b0;
        if (v != prev[i]) begin
            len    = run[i];
            run[i] = 1;
            if (nedge[i] == 0) begin
                cur[i].st = 1'b0;
                nedge[i]  = 1;
            end else begin
                if (v) begin
                    cur[i].lk = (nedge[i] >= 2) && (len == cur[i].hl);
                    cur[i].ll = len;
                end else begin
                    cur[i].lk = (nedge[i] >= 2) && (len == cur[i].ll);
                    cur[i].hl = len;
                end
                cur[i].per = cur[i].hl + cur[i].ll;
                cur[i].mc  = len - 1;
                cur[i].mv  = 1'b1;
                nedge[i]   = 2;
            end
        end else begin
            if (nedge[i] != 0 && run[i] == maxv[i]) begin
                cur[i].st = 1'b1;
                cur[i].lk = 1'b0;
                nedge[i]  = 0;
            end
            if (run[i] != maxv[i]) run[i] = run[i] + 1;
        end
        prev[i] = v;
    endtask

    task automatic cyc(input bit v);
        exp_t ea, eb;
        sig_in = v;
        model_step(0, v);
        model_step(1, v);
        qa.push_back(cur[0]);
        qb.push_back(cur[1]);
        @(posedge cin);
        #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("a_high_len",   64'(a_hl),  64'(ea.hl));
        chk("a_low_len",    64'(a_ll),  64'(ea.ll));
        chk("a_period",     64'(a_per), 64'(ea.per));
        chk("a_max_count",  64'(a_mc),  64'(ea.mc));
        chk("a_meas_valid", 64'(a_mv),  64'(ea.mv));
        chk("a_locked",     64'(a_lk),  64'(ea.lk));
        chk("a_stalled",    64'(a_st),  64'(ea.st));
        chk("b_high_len",   64'(b_hl),  64'(eb.hl));
        chk("b_low_len",    64'(b_ll),  64'(eb.ll));
        chk("b_period",     64'(b_per), 64'(eb.per));
        chk("b_max_count",  64'(b_mc),  64'(eb.mc));
        chk("b_meas_valid", 64'(b_mv),  64'(eb.mv));
        chk("b_locked",     64'(b_lk),  64'(eb.lk));
        chk("b_stalled",    64'(b_st),  64'(eb.st));
    endtask

    task automatic phase(input bit v, input int n);
        repeat (n) cyc(v);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_a_lens"}, {a_hl, a_ll}, 64'd0);
        chk({tag, "_a_per_mc"}, {31'd0, a_per} | {32'd0, a_mc}, 64'd0);
        chk({tag, "_a_flags"}, {61'd0, a_mv, a_lk, a_st}, 64'd0);
        chk({tag, "_b_all"}, {38'd0, b_hl, b_ll, b_per, b_mc, b_mv, b_lk, b_st}, 64'd0);
    endtask

    initial begin
        maxv[0] = 64'hFFFF_FFFF;
        maxv[1] = 15;
        rst_n   = 1'b0;
        sig_in  = 1'b0;
        repeat (2) @(posedge cin);
        #1;
        chk_zero("reset");
        @(negedge cin);
        rst_n = 1'b1;
        model_reset();

        // Symmetric divider, terminal count 3
        repeat (6) begin
            phase(1'b1, 4);
            phase(1'b0, 4);
        end
        chk("sym_high_len", 64'(a_hl), 64'd4);
        chk("sym_low_len",  64'(a_ll), 64'd4);
        chk("sym_period",   64'(a_per), 64'd8);
        chk("sym_max_count", 64'(a_mc), 64'd3);
        chk("sym_locked",   64'(a_lk), 64'd1);

        // Asymmetric 3 high / 5 low
        repeat (5) begin
            phase(1'b1, 3);
            phase(1'b0, 5);
        end
        chk("asym_high_len", 64'(a_hl), 64'd3);
        chk("asym_low_len",  64'(a_ll), 64'd5);
        chk("asym_period",   64'(a_per), 64'd8);
        chk("asym_locked",   64'(a_lk), 64'd0);

        // Lock, then hold high long enough to stall the narrow instance
        repeat (3) begin
            phase(1'b1, 4);
            phase(1'b0, 4);
        end
        phase(1'b1, 20);
        chk("hold_b_stalled", 64'(b_st), 64'd1);
        chk("hold_b_locked",  64'(b_lk), 64'd0);
        chk("hold_a_stalled", 64'(a_st), 64'd0);
        phase(1'b0, 3);
        phase(1'b1, 3);
        phase(1'b0, 3);

        // Phases of exactly 15 cycles: edge coincides with saturation
        phase(1'b1, 15);
        phase(1'b0, 15);
        phase(1'b1, 15);
        phase(1'b0, 3);
        chk("sat15_b_low_len", 64'(b_ll), 64'd15);
        chk("sat15_b_stalled", 64'(b_st), 64'd0);

        // Asynchronous reset mid-phase while locked
        repeat (3) begin
            phase(1'b1, 4);
            phase(1'b0, 4);
        end
        phase(1'b1, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        #1;
        rst_n = 1'b1;
        model_reset();
        phase(1'b1, 2);
        repeat (3) begin
            phase(1'b0, 4);
            phase(1'b1, 4);
        end

        // Toggle every cycle
        repeat (10) begin
            cyc(1'b1);
            cyc(1'b0);
        end
        chk("tog_period",     64'(a_per), 64'd2);
        chk("tog_meas_valid", 64'(a_mv),  64'd1);
        chk("tog_locked",     64'(a_lk),  64'd1);

        // Random phase lengths straddling the narrow instance's saturation point
        for (int k = 0; k < 60; k++) begin
            phase(k[0], int'($urandom_range(1, 20)));
        end
        phase(1'b0, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
